// File: rtl/adc3wire_cmd_queue_if.sv
// rtl/adc3wire_cmd_queue_if.sv - bus-side and shifter-side signal bundle for adc3wire_cmd_queue
interface adc3wire_cmd_queue_if #(
  parameter int DEPTH_LOG2 = 3
);
  // bus-side write port and flag clear
  logic                  wr_en;
  logic [3:0]            wr_addr;
  logic [15:0]           wr_data;
  logic                  ovf_clr;
  // shifter handshake
  logic                  config_start;
  logic [3:0]            config_addr;
  logic [15:0]           config_data;
  logic                  config_idle;
  logic                  config_done;
  // status back to the bus side
  logic                  busy;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DEPTH_LOG2:0]   fifo_count;
  logic                  overflow;
  logic                  timeout_err;
  logic [15:0]           tx_count;

  // bus controller plus shifter: everything the queue consumes
  modport master (
    output wr_en, wr_addr, wr_data, ovf_clr, config_idle, config_done,
    input  config_start, config_addr, config_data, busy, fifo_full, fifo_empty,
           fifo_count, overflow, timeout_err, tx_count
  );

  // the command queue itself
  modport slave (
    input  wr_en, wr_addr, wr_data, ovf_clr, config_idle, config_done,
    output config_start, config_addr, config_data, busy, fifo_full, fifo_empty,
           fifo_count, overflow, timeout_err, tx_count
  );
endinterface

// File: rtl/adc3wire_cmd_queue.sv
// rtl/adc3wire_cmd_queue.sv - command FIFO and sequencer feeding the ADC 3-wire shifter (optional ADC3WIRE_INIT_SEQ_EN boot sequence)
module adc3wire_cmd_queue #(
  parameter int DEPTH_LOG2 = 3,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  adc3wire_cmd_queue_if.slave cq
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [7:0]            GAP_LOAD = 8'(GAP_CYCLES);
  localparam logic [15:0]           TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);

`ifdef ADC3WIRE_INIT_SEQ_EN
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;
  localparam state_t RESET_STATE = S_INIT;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;
  localparam state_t RESET_STATE = S_IDLE;
`endif

  // FIFO storage and bookkeeping
  logic [19:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  full, empty, push, pop, ovf_set;
  logic [19:0]           head;

  // sequencer state and registered outputs
  state_t                state_q;
  state_t                resume_state;
  logic                  config_start_q;
  logic [3:0]            config_addr_q;
  logic [15:0]           config_data_q;
  logic [7:0]            gap_q;
  logic [15:0]           to_cnt_q;
  logic [15:0]           tx_count_q;
  logic                  timeout_err_q;
  logic                  gap_expired;

`ifdef ADC3WIRE_INIT_SEQ_EN
  logic [1:0]            init_idx_q;
  logic [19:0]           init_cmd;

  // the two boot commands, selected by how many have already gone out
  assign init_cmd     = (init_idx_q == 2'd0) ? {4'h0, 16'h7FFF} : {4'h1, 16'hBAFF};
  // keep returning to INIT until both boot commands have been issued
  assign resume_state = (init_idx_q == 2'd2) ? S_IDLE : S_INIT;
`else
  assign resume_state = S_IDLE;
`endif

  // full/empty come straight off the count register, so no input reaches them
  assign full        = count_q[DEPTH_LOG2];
  assign empty       = (count_q == '0);
  // acceptance uses the pre-edge fullness, so a same-cycle pop never rescues a write
  assign push        = cq.wr_en & ~full;
  assign ovf_set     = cq.wr_en & full;
  assign head        = mem_q[rd_ptr_q];
  assign gap_expired = (gap_q == 8'd0);
  assign pop         = (state_q == S_IDLE) & ~empty & cq.config_idle & gap_expired;

  // next-state for pointers, occupancy and the sticky overflow (set beats clear)
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = (overflow_q & ~cq.ovf_clr) | ovf_set;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO payload; stale contents are harmless because reset clears the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cq.wr_addr, cq.wr_data};
  end

  // FIFO pointers, occupancy and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // sequencer: issue one command at a time, enforce the post-done gap, abort on timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RESET_STATE;
      config_start_q <= 1'b0;
      config_addr_q  <= 4'h0;
      config_data_q  <= 16'h0000;
      gap_q          <= 8'd0;
      to_cnt_q       <= 16'd0;
      tx_count_q     <= 16'd0;
      timeout_err_q  <= 1'b0;
`ifdef ADC3WIRE_INIT_SEQ_EN
      init_idx_q     <= 2'd0;
`endif
    end else begin
      config_start_q <= 1'b0;
      timeout_err_q  <= timeout_err_q & ~cq.ovf_clr;
      case (state_q)
`ifdef ADC3WIRE_INIT_SEQ_EN
        S_INIT: begin
          if (cq.config_idle && gap_expired) begin
            config_addr_q  <= init_cmd[19:16];
            config_data_q  <= init_cmd[15:0];
            config_start_q <= 1'b1;
            init_idx_q     <= init_idx_q + 2'd1;
            state_q        <= S_ISSUE;
          end else if (!gap_expired) begin
            gap_q <= gap_q - 8'd1;
          end
        end
`endif
        S_IDLE: begin
          if (pop) begin
            config_addr_q  <= head[19:16];
            config_data_q  <= head[15:0];
            config_start_q <= 1'b1;
            state_q        <= S_ISSUE;
          end else if (!gap_expired) begin
            gap_q <= gap_q - 8'd1;
          end
        end
        S_ISSUE: begin
          to_cnt_q <= 16'd0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (cq.config_done) begin
            tx_count_q <= tx_count_q + 16'd1;
            gap_q      <= GAP_LOAD;
            state_q    <= resume_state;
          end else if (to_cnt_q == TO_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= resume_state;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cq.config_start = config_start_q;
  assign cq.config_addr  = config_addr_q;
  assign cq.config_data  = config_data_q;
  assign cq.fifo_count   = count_q;
  assign cq.fifo_full    = full;
  assign cq.fifo_empty   = empty;
  assign cq.overflow     = overflow_q;
  assign cq.timeout_err  = timeout_err_q;
  assign cq.tx_count     = tx_count_q;
  assign cq.busy         = (state_q != S_IDLE) | ~empty;

endmodule

// File: tb/tb_adc3wire_cmd_queue.sv
// tb/tb_adc3wire_cmd_queue.sv - randomized self-checking bench for adc3wire_cmd_queue
module tb_adc3wire_cmd_queue;

  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;
  localparam int GAP   = 16;
  localparam int TO    = 1023;
`ifdef ADC3WIRE_INIT_SEQ_EN
  localparam int N_INIT = 2;
`else
  localparam int N_INIT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc3wire_cmd_queue_if #(.DEPTH_LOG2(DL)) ifc ();

  adc3wire_cmd_queue #(
    .DEPTH_LOG2 (DL),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cq    (ifc)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shifter model controls
  logic idle_en  = 1'b1;
  logic shf_busy = 1'b0;
  logic shf_done = 1'b0;
  logic respond  = 1'b1;
  logic rand_lat = 1'b0;
  int   lat      = 544;
  int   shf_l;
  assign ifc.config_idle = idle_en & ~shf_busy;
  assign ifc.config_done = shf_done;

  // scoreboard
  logic [19:0] iss_q[$];
  int          iss_cyc[$];
  int          done_cyc[$];
  logic [19:0] exp_q[$];
  int          acc, pop_base, done_base, chk_idx;
  logic        exp_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // start monitor
  initial forever begin
    @(posedge clk); #1;
    if (rst_n && ifc.config_start) begin
      iss_q.push_back({ifc.config_addr, ifc.config_data});
      iss_cyc.push_back(cyc);
    end
  end

  // shifter: goes busy on start, pulses done after a latency
  initial forever begin
    @(posedge clk); #1;
    if (rst_n && ifc.config_start && respond) begin
      shf_l = rand_lat ? int'($urandom_range(2, 60)) : lat;
      shf_busy = 1'b1;
      repeat (shf_l - 1) @(posedge clk);
      #1;
      shf_done = 1'b1;
      done_cyc.push_back(cyc + 1);
      @(posedge clk); #1;
      shf_done = 1'b0;
      shf_busy = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic new_epoch();
    pop_base  = iss_q.size() + N_INIT;
    done_base = done_cyc.size();
    acc       = 0;
    chk_idx   = 0;
    exp_ovf   = 1'b0;
    exp_q.delete();
  endtask

  function automatic int model_cnt();
    return acc - (iss_q.size() - pop_base);
  endfunction

  task automatic write(input logic [3:0] a, input logic [15:0] d);
    ifc.wr_en = 1'b1; ifc.wr_addr = a; ifc.wr_data = d;
    tick();
    ifc.wr_en = 1'b0;
  endtask

  // model-tracked write: a write is kept only if the queue had room before the edge
  task automatic mwrite(input logic [3:0] a, input logic [15:0] d);
    int cnt;
    cnt = model_cnt();
    check("cnt_pre", 32'(ifc.fifo_count), 32'(cnt));
    if (cnt < DEPTH) begin
      exp_q.push_back({a, d});
      acc++;
    end else begin
      exp_ovf = 1'b1;
    end
    write(a, d);
  endtask

  task automatic drain(input int budget);
    int g;
    g = budget;
    while (g > 0 && !((iss_q.size() - pop_base) >= acc && !shf_busy && !shf_done)) begin
      tick();
      g--;
    end
    check("drain", 32'(g > 0), 32'd1);
    tick(GAP + 3);
  endtask

  task automatic check_order();
    for (int i = chk_idx; i < exp_q.size(); i++) begin
      if (pop_base + i < iss_q.size()) check("order", 32'(iss_q[pop_base + i]), 32'(exp_q[i]));
      else check("order_missing", 32'hFFFF_FFFF, 32'(exp_q[i]));
    end
    chk_idx = exp_q.size();
  endtask

  task automatic wait_starts(input int n, input int budget);
    int g;
    g = budget;
    while (g > 0 && iss_q.size() < n) begin tick(); g--; end
    check("start_wait", 32'(iss_q.size() >= n), 32'd1);
  endtask

  task automatic pulse_clr();
    ifc.ovf_clr = 1'b1;
    tick();
    ifc.ovf_clr = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_count"}, 32'(ifc.fifo_count), 32'd0);
    check({tag, "_empty"}, 32'(ifc.fifo_empty), 32'd1);
    check({tag, "_full"},  32'(ifc.fifo_full), 32'd0);
    check({tag, "_start"}, 32'(ifc.config_start), 32'd0);
    check({tag, "_addr"},  32'(ifc.config_addr), 32'd0);
    check({tag, "_data"},  32'(ifc.config_data), 32'd0);
    check({tag, "_ovf"},   32'(ifc.overflow), 32'd0);
    check({tag, "_to"},    32'(ifc.timeout_err), 32'd0);
    check({tag, "_tx"},    32'(ifc.tx_count), 32'd0);
    check({tag, "_busy"},  32'(ifc.busy), (N_INIT > 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int n_cyc, s, r, first, dfirst, rs, rd, n, s0;
    logic [19:0] a_cmd;
    ifc.wr_en = 1'b0; ifc.wr_addr = 4'h0; ifc.wr_data = 16'h0; ifc.ovf_clr = 1'b0;

    // reset state
    tick(3);
    check_reset_vals("rst");
    rst_n = 1'b1;
    new_epoch();

`ifdef ADC3WIRE_INIT_SEQ_EN
    // boot sequence, with a bus write landing during INIT
    s0 = iss_q.size();
    write(4'h9, 16'h1234);
    exp_q.push_back({4'h9, 16'h1234});
    acc++;
    drain(5000);
    check("init0", 32'(iss_q[s0]), 32'h0_7FFF);
    check("init1", 32'(iss_q[s0 + 1]), 32'h1_BAFF);
    check_order();
`endif

    // single write timing and contents
    lat = 544;
    mwrite(4'h3, 16'hA5C3);
    n_cyc = cyc;
    check("single_cnt", 32'(ifc.fifo_count), 32'd1);
    tick();
    check("single_start_hi", 32'(ifc.config_start), 32'd1);
    check("single_addr", 32'(ifc.config_addr), 32'h3);
    check("single_data", 32'(ifc.config_data), 32'hA5C3);
    tick();
    check("single_start_lo", 32'(ifc.config_start), 32'd0);
    check("single_start_cyc", 32'(iss_cyc[iss_cyc.size() - 1]), 32'(n_cyc + 1));
    drain(2000);
    check("single_tx", 32'(ifc.tx_count), 32'(done_cyc.size() - done_base));
    check("single_busy", 32'(ifc.busy), 32'd0);
    check_order();

    // burst of DEPTH+1 while shifter holds off; last write also carries ovf_clr
    lat = 100;
    idle_en = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      if (i == DEPTH) ifc.ovf_clr = 1'b1;
      mwrite(4'(i), 16'($urandom));
      ifc.ovf_clr = 1'b0;
    end
    check("burst_cnt", 32'(ifc.fifo_count), 32'(DEPTH));
    check("burst_full", 32'(ifc.fifo_full), 32'd1);
    check("burst_empty", 32'(ifc.fifo_empty), 32'd0);
    check("burst_ovf", 32'(ifc.overflow), 32'(exp_ovf));
    check("burst_busy", 32'(ifc.busy), 32'd1);
    tick(5);
    first  = iss_q.size();
    dfirst = done_cyc.size();
    r = cyc;
    idle_en = 1'b1;
    wait_starts(first + DEPTH, 5000);
    check("burst_first_start", 32'(iss_cyc[first]), 32'(r + 1));
    for (int j = 1; j < DEPTH; j++)
      check("burst_gap", 32'(iss_cyc[first + j]), 32'(done_cyc[dfirst + j - 1] + 1 + GAP));
    drain(3000);
    check_order();
    check("burst_tx", 32'(ifc.tx_count), 32'(done_cyc.size() - done_base));
    check("burst_ovf_held", 32'(ifc.overflow), 32'd1);
    pulse_clr();
    check("burst_ovf_clr", 32'(ifc.overflow), 32'(exp_ovf));

    // simultaneous push and pop at count 2
    idle_en = 1'b0;
    mwrite(4'hA, 16'h0A0A);
    mwrite(4'hB, 16'h0B0B);
    check("pp_cnt_before", 32'(ifc.fifo_count), 32'd2);
    idle_en = 1'b1;
    mwrite(4'hC, 16'h0C0C);
    check("pp_cnt_after", 32'(ifc.fifo_count), 32'd2);
    a_cmd = {4'hA, 16'h0A0A};
    check("pp_oldest", 32'(iss_q[iss_q.size() - 1]), 32'(a_cmd));
    drain(3000);
    check_order();

    // randomized traffic against the model
    rand_lat = 1'b1;
    rs = iss_q.size();
    rd = done_cyc.size();
    for (int i = 0; i < 40; i++) begin
      tick($urandom_range(0, 25));
      mwrite(4'($urandom), 16'($urandom));
    end
    drain(8000);
    rand_lat = 1'b0;
    check_order();
    check("rnd_ovf", 32'(ifc.overflow), 32'(exp_ovf));
    check("rnd_tx", 32'(ifc.tx_count), 32'(16'(done_cyc.size() - done_base)));
    n = iss_q.size() - rs;
    for (int j = 1; j < n; j++)
      check("rnd_gap", 32'(iss_cyc[rs + j] >= done_cyc[rd + j - 1] + 1 + GAP), 32'd1);
    pulse_clr();

    // timeout: shifter never answers
    respond = 1'b0;
    mwrite(4'h5, 16'h5555);
    wait_starts(pop_base + acc, 100);
    s = iss_cyc[iss_cyc.size() - 1];
    while (cyc < s + TO) tick();
    check("to_before", 32'(ifc.timeout_err), 32'd0);
    check("to_busy_before", 32'(ifc.busy), 32'd1);
    tick();
    check("to_set", 32'(ifc.timeout_err), 32'd1);
    check("to_busy_after", 32'(ifc.busy), 32'd0);
    check("to_tx", 32'(ifc.tx_count), 32'(16'(done_cyc.size() - done_base)));
    pulse_clr();
    check("to_clr", 32'(ifc.timeout_err), 32'd0);
    respond = 1'b1;
    check_order();
    tick(GAP + 3);

    // reset while waiting on the shifter with 3 entries queued
    lat = 544;
    for (int i = 0; i < 4; i++) mwrite(4'(i + 4), 16'($urandom));
    tick(10);
    check("mid_cnt", 32'(ifc.fifo_count), 32'd3);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid");
    tick(2);
    rst_n = 1'b1;
    new_epoch();
    s0 = iss_q.size();
    tick(700);
`ifndef ADC3WIRE_INIT_SEQ_EN
    check("mid_no_start", 32'(iss_q.size()), 32'(s0));
    check("mid_cnt_after", 32'(ifc.fifo_count), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
